// File: rtl/alu_cmd_issuer.sv
// Initiator front end for the 8-bit ALU: queues tagged commands, steps each one
// through the ALU and returns tagged results in command order.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int          PW     = $clog2(DEPTH);
  localparam logic [PW:0] FULL   = (PW+1)'(DEPTH);
  localparam logic [2:0]  OP_ADD = 3'b000;
  localparam logic [2:0]  OP_SUB = 3'b001;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [PW:0]      count_n;
  state_t           state;
  logic [TAG_W-1:0] cur_tag;
  logic             push;
  logic             pop;
  logic             at_slot;
  logic             go_idle;

  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  // The ALU is free in IDLE, or in HOLD on the edge the response is taken.
  assign at_slot   = (state == IDLE) || (state == HOLD && rsp_ready);
  assign pop       = at_slot && (count != '0);
  assign go_idle   = at_slot && (count == '0);
  assign head      = mem[rd_ptr];

  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves count_n
    // unassigned and no latch is inferred.
    count_n = count;
    if (push && !pop)
      count_n = count + 1'b1;
    else if (pop && !push)
      count_n = count - 1'b1;
  end

  // NOTE: command storage has no reset; count and pointers alone say which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cur_tag    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_tag    <= '0;
      busy       <= 1'b0;
    end else begin
      busy <= !go_idle || (count_n != '0);

      case (state)
        DRIVE:   state <= CAPTURE;
        CAPTURE: begin
          rsp_result <= alu_result;
          // The ALU keeps its last carry across logic ops; only arithmetic owns it.
          rsp_carry  <= alu_carry && (alu_opcode == OP_ADD || alu_opcode == OP_SUB);
          rsp_tag    <= cur_tag;
          rsp_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase

      // A pop launches the next command, whether from IDLE or straight out of HOLD.
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_opcode <= head.op;
        cur_tag    <= head.tag;
        state      <= DRIVE;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus randomized
// traffic scored against an in-order reference queue.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_a = '0;
  logic [7:0]       cmd_b = '0;
  logic [2:0]       cmd_op = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_opcode;
  logic [7:0]       alu_result = '0;
  logic             alu_carry = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // 9-bit ALU outcome: bit 8 is carry-out for ADD, borrow for SUB.
  function automatic logic [8:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, a << b[2:0]};
      default: return {1'b0, a >> b[2:0]};
    endcase
  endfunction

  // Registered ALU stand-in; carry is only updated by arithmetic ops.
  logic [8:0] alu_out;
  assign alu_out = alu_calc(alu_a, alu_b, alu_opcode);
  always @(posedge clk) begin
    alu_result <= alu_out[7:0];
    if (alu_opcode == 3'd0 || alu_opcode == 3'd1)
      alu_carry <= alu_out[8];
  end

  typedef struct packed {
    logic [7:0]       result;
    logic             carry;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  rsp_t exp_q[$];

  function automatic rsp_t ref_rsp(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op, input logic [TAG_W-1:0] tag);
    logic [8:0] s;
    rsp_t r;
    s        = alu_calc(a, b, op);
    r.result = s[7:0];
    r.carry  = (op == 3'd0 || op == 3'd1) ? s[8] : 1'b0;
    r.tag    = tag;
    return r;
  endfunction

  // Scoreboard and backpressure-stability monitor, sampling on the falling edge.
  bit   hold_pending = 1'b0;
  rsp_t prev_payload;
  rsp_t now_payload;
  rsp_t exp_item;
  always @(negedge clk) begin
    if (rst) begin
      now_payload = {rsp_result, rsp_carry, rsp_tag};
      if (cmd_valid && cmd_ready)
        exp_q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op, cmd_tag));
      if (hold_pending) begin
        check("hold_valid", 32'(rsp_valid), 1);
        check("hold_payload", 32'(now_payload), 32'(prev_payload));
      end
      if (rsp_valid && rsp_ready) begin
        n_hs++;
        check("rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_item = exp_q.pop_front();
          check("sb_result", 32'(rsp_result), 32'(exp_item.result));
          check("sb_carry", 32'(rsp_carry), 32'(exp_item.carry));
          check("sb_tag", 32'(rsp_tag), 32'(exp_item.tag));
        end
      end
      hold_pending = rsp_valid && !rsp_ready;
      prev_payload = now_payload;
    end
  end

  task automatic check_idle_outputs(input string p);
    check({p, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({p, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({p, "_rsp_result"}, 32'(rsp_result), 0);
    check({p, "_rsp_carry"}, 32'(rsp_carry), 0);
    check({p, "_rsp_tag"}, 32'(rsp_tag), 0);
    check({p, "_alu_a"}, 32'(alu_a), 0);
    check({p, "_alu_b"}, 32'(alu_b), 0);
    check({p, "_alu_opcode"}, 32'(alu_opcode), 0);
    check({p, "_busy"}, 32'(busy), 0);
  endtask

  // Called one step after a rising edge; leaves rst released at the same phase.
  task automatic do_reset(input string p, input int cycles);
    cmd_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0;
    #1;
    check_idle_outputs({p, "_in_rst"});
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send_cmd(input int a, input int b, input int op, input int tag,
                          input int max_wait, output bit ok);
    cmd_valid = 1'b1;
    cmd_a     = 8'(a);
    cmd_b     = 8'(b);
    cmd_op    = 3'(op);
    cmd_tag   = TAG_W'(tag);
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input int r, input int c, input int t,
                            output int lat);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_valid"}, 32'(rsp_valid), 1);
    check({name, "_result"}, 32'(rsp_result), r);
    check({name, "_carry"}, 32'(rsp_carry), c);
    check({name, "_tag"}, 32'(rsp_tag), t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    int lat;
    int hs0;
    int i;

    // Reset values and a quiet period after release.
    #1;
    do_reset("init", 3);
    check_idle_outputs("init_post");
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= rsp_valid; end
    check("init_quiet", 32'(seen), 0);
    @(posedge clk); #1;

    // Single ADD: latency and busy framing.
    rsp_ready = 1'b1;
    send_cmd('hF0, 'h20, 0, 3, 5, ok);
    check("add_accept", 32'(ok), 1);
    check("add_busy_hi", 32'(busy), 1);
    expect_rsp("add", 'h10, 1, 3, lat);
    check("add_latency", 32'(lat), 3);
    check("add_busy_lo", 32'(busy), 0);

    // Stale carry from SUB must not leak into the following AND.
    send_cmd('h05, 'h06, 1, 1, 5, ok);
    check("sub_accept", 32'(ok), 1);
    send_cmd('hFF, 'h0F, 2, 2, 5, ok);
    check("and_accept", 32'(ok), 1);
    expect_rsp("sub", 'hFF, 1, 1, lat);
    expect_rsp("and", 'h0F, 0, 2, lat);

    // FIFO full under backpressure: DEPTH+1 accepted, the next one held off.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_cmd(k * 16 + 1, k + 2, 0, k, 1, ok);
      check($sformatf("full_accept%0d", k), 32'(ok), 1);
    end
    check("full_ready", 32'(cmd_ready), 0);
    send_cmd(5 * 16 + 1, 7, 0, 5, 5, ok);
    check("full_hold", 32'(ok), 0);
    rsp_ready = 1'b1;
    fork
      begin
        bit ok5;
        send_cmd(5 * 16 + 1, 7, 0, 5, 20, ok5);
        check("full_accept5", 32'(ok5), 1);
      end
      begin
        int l;
        for (int k = 0; k < 6; k++) begin
          expect_rsp($sformatf("full_rsp%0d", k), (k * 16 + 1 + k + 2) % 256, 0, k, l);
          if (k > 0) check($sformatf("full_gap%0d", k), 32'(l), 2);
        end
      end
    join

    // Payload stability while held, then exactly one handshake.
    send_cmd('hFF, 'h01, 0, 6, 5, ok);
    expect_rsp("carry_set", 'h00, 1, 6, lat);
    rsp_ready = 1'b0;
    send_cmd('hAA, 'h55, 4, 7, 5, ok);
    check("xor_accept", 32'(ok), 1);
    expect_rsp("xor", 'hFF, 0, 7, lat);
    repeat (10) @(posedge clk);
    #1;
    check("xor_held_valid", 32'(rsp_valid), 1);
    check("xor_held_result", 32'(rsp_result), 'hFF);
    check("xor_held_carry", 32'(rsp_carry), 0);
    check("xor_held_tag", 32'(rsp_tag), 7);
    hs0 = n_hs;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("xor_one_hs", 32'(n_hs - hs0), 1);

    // Randomized traffic with random backpressure, then drain.
    for (int c = 0; c < 600; c++) begin
      cmd_valid = ($urandom_range(0, 99) < 60);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_op    = 3'($urandom);
      cmd_tag   = TAG_W'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 65);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("rand_drained", 32'(exp_q.size()), 0);
    check("rand_busy_lo", 32'(busy), 0);

    // Reset while CAPTURE is in progress with two commands queued.
    send_cmd('h11, 'h22, 0, 8, 5, ok);
    send_cmd('h33, 'h44, 1, 9, 5, ok);
    send_cmd('h55, 'h66, 3, 10, 5, ok);
    check("mid_busy", 32'(busy), 1);
    hs0 = n_hs;
    do_reset("mid", 2);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= rsp_valid; end
    @(posedge clk); #1;
    check("mid_quiet", 32'(seen), 0);
    check("mid_no_hs", 32'(n_hs - hs0), 0);
    check_idle_outputs("mid_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
